// File: rtl/cplx_mat2x2_mult_seq.sv
// Sequential signed complex 2x2 matrix multiplier (C = A*B or C = A*B^H).
// One complex MAC is time-shared over the eight products; streams in and out via valid/ready.
module cplx_mat2x2_mult_seq #(
  parameter int W  = 8,
  parameter int OW = 2*W+2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [W-1:0]  in_re,
  input  logic signed [W-1:0]  in_im,
  input  logic                 in_herm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [OW-1:0] out_re,
  output logic signed [OW-1:0] out_im,
  output logic                 out_last,
  output logic                 busy
);

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

  state_t state;
  logic [2:0] beat;
  logic [2:0] k;
  logic [1:0] slot;
  logic [1:0] slot_nxt;
  logic       herm;
  logic       in_fire;

  logic signed [W-1:0]  elem_re [8];
  logic signed [W-1:0]  elem_im [8];
  logic signed [OW-1:0] res_re  [4];
  logic signed [OW-1:0] res_im  [4];
  logic signed [OW-1:0] acc_re, acc_im;

  // Operand selection for the current MAC step
  logic [1:0]           e;
  logic                 m;
  logic [2:0]           a_idx, b_idx;
  logic signed [OW-1:0] ar_x, ai_x, br_x, bi_x;
  logic signed [OW-1:0] p_re, p_im;

  function automatic logic signed [OW-1:0] sx(input logic signed [W-1:0] v);
    return {{(OW-W){v[W-1]}}, v};
  endfunction

  assign in_fire  = in_valid && in_ready;
  assign e        = k[2:1];
  assign m        = k[0];
  assign slot_nxt = slot + 2'd1;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    a_idx = 3'd0;
    b_idx = 3'd4;
    ar_x  = '0;
    ai_x  = '0;
    br_x  = '0;
    bi_x  = '0;
    // A[i][m] sits at 2*i+m; B[r][c] at 4+2*r+c. Hermitian mode reads B transposed.
    a_idx = {1'b0, e[1], m};
    b_idx = herm ? {1'b1, e[0], m} : {1'b1, m, e[0]};
    ar_x  = sx(elem_re[a_idx]);
    ai_x  = sx(elem_im[a_idx]);
    br_x  = sx(elem_re[b_idx]);
    // Negating after widening keeps conj(-2^(W-1)) representable.
    bi_x  = herm ? -sx(elem_im[b_idx]) : sx(elem_im[b_idx]);
  end

  assign p_re = ar_x * br_x - ai_x * bi_x;
  assign p_im = ar_x * bi_x + ai_x * br_x;

  // NOTE: element and result storage carry no reset; the FSM never reads them before they are written.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      elem_re[beat] <= in_re;
      elem_im[beat] <= in_im;
    end
  end

  always_ff @(posedge clk) begin
    if (state == COMPUTE && m) begin
      res_re[e] <= acc_re + p_re;
      res_im[e] <= acc_im + p_im;
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= LOAD;
      beat      <= 3'd0;
      k         <= 3'd0;
      slot      <= 2'd0;
      herm      <= 1'b0;
      acc_re    <= '0;
      acc_im    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (in_fire) begin
            if (beat == 3'd0) herm <= in_herm;
            if (beat == 3'd7) begin
              beat     <= 3'd0;
              k        <= 3'd0;
              state    <= COMPUTE;
              in_ready <= 1'b0;
              busy     <= 1'b1;
            end else begin
              beat <= beat + 3'd1;
            end
          end
        end
        COMPUTE: begin
          k      <= k + 3'd1;
          acc_re <= m ? acc_re + p_re : p_re;
          acc_im <= m ? acc_im + p_im : p_im;
          if (k == 3'd7) begin
            // Slot 0 was written long ago; slot 3 lands on this same edge.
            state     <= OUTPUT;
            slot      <= 2'd0;
            out_valid <= 1'b1;
            out_last  <= 1'b0;
            out_re    <= res_re[0];
            out_im    <= res_im[0];
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            if (slot == 2'd3) begin
              state     <= LOAD;
              beat      <= 3'd0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              in_ready  <= 1'b1;
              busy      <= 1'b0;
            end else begin
              slot     <= slot_nxt;
              out_re   <= res_re[slot_nxt];
              out_im   <= res_im[slot_nxt];
              out_last <= (slot_nxt == 2'd3);
            end
          end
        end
        default: begin
          state    <= LOAD;
          in_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cplx_mat2x2_mult_seq.sv
// Self-checking bench for cplx_mat2x2_mult_seq: directed cases plus random matrices
// compared against a plain-arithmetic complex matrix product.
module tb_cplx_mat2x2_mult_seq;

  localparam int W  = 8;
  localparam int OW = 2*W+2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [W-1:0]  in_re, in_im;
  logic                 in_herm;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [OW-1:0] out_re, out_im;
  logic                 out_last;
  logic                 busy;

  int checks   = 0;
  int failures = 0;

  cplx_mat2x2_mult_seq #(.W(W), .OW(OW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_re(in_re), .in_im(in_im), .in_herm(in_herm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_re(out_re), .out_im(out_im), .out_last(out_last),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int got, input int exp_v);
    checks++;
    if (got !== exp_v) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp_v);
    end
  endtask

  // Reference: C[i][j] = sum_m A[i][m] * Bx[m][j], Bx = B or B^H.
  task automatic ref_model(input int xr[8], input int xi[8], input bit h,
                           output int cr[4], output int ci[4]);
    for (int e = 0; e < 4; e++) begin
      int i, j, sr, si;
      i = e / 2; j = e % 2; sr = 0; si = 0;
      for (int mm = 0; mm < 2; mm++) begin
        int ar, ai, br, bi;
        ar = xr[2*i+mm];
        ai = xi[2*i+mm];
        if (!h) begin
          br = xr[4 + 2*mm + j];
          bi = xi[4 + 2*mm + j];
        end else begin
          br = xr[4 + 2*j + mm];
          bi = -xi[4 + 2*j + mm];
        end
        sr += ar*br - ai*bi;
        si += ar*bi + ai*br;
      end
      cr[e] = sr;
      ci[e] = si;
    end
  endtask

  // Returns at the negedge before the edge that accepts beat 7.
  task automatic load(input int xr[8], input int xi[8], input bit h,
                      input bit flip_herm, input bit gaps);
    for (int b = 0; b < 8; b++) begin
      int n;
      if (gaps && ($urandom_range(0, 2) == 0)) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_re    = W'($urandom);
        in_im    = W'($urandom);
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_re    = xr[b][W-1:0];
      in_im    = xi[b][W-1:0];
      in_herm  = (b == 0) ? h : (flip_herm ? ~h : h);
      n = 0;
      while (!in_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("load_in_ready", int'(in_ready), 1);
    end
  endtask

  task automatic collect(input int er[4], input int ei[4], input int stall_slot,
                         input bit junk);
    int cyc, slot, first, stalled, last_edge;
    cyc = -1; slot = 0; first = -1; stalled = 0; last_edge = -1;
    while (slot < 4 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (junk) begin
        in_valid = 1'b1;
        in_re    = W'($urandom);
        in_im    = W'($urandom);
        in_herm  = 1'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      check("busy_in_ready_low", int'(in_ready), 0);
      check("busy_high", int'(busy), 1);
      if (out_valid) begin
        if (first < 0) first = cyc;
        check($sformatf("out_re_slot%0d", slot), int'(out_re), er[slot]);
        check($sformatf("out_im_slot%0d", slot), int'(out_im), ei[slot]);
        check($sformatf("out_last_slot%0d", slot), int'(out_last), int'(slot == 3));
        if (slot == stall_slot && stalled < 5) begin
          out_ready = 1'b0;
          stalled++;
        end else begin
          out_ready = 1'b1;
          if (slot == 3) last_edge = cyc + 1;
          slot++;
        end
      end else begin
        out_ready = 1'($urandom);
      end
    end
    check("xfer_count", slot, 4);
    check("first_valid_latency", first, 8);
    if (stall_slot < 0) check("last_xfer_edge", last_edge, 12);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("post_in_ready", int'(in_ready), 1);
    check("post_out_valid", int'(out_valid), 0);
    check("post_busy", int'(busy), 0);
    check("post_hold_re", int'(out_re), er[3]);
    check("post_hold_im", int'(out_im), ei[3]);
  endtask

  int ar[8], ai[8], er[4], ei[4];
  int t1r[8], t1i[8], t1er[4], t1ei[4];

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_re = '0; in_im = '0; in_herm = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_out_last", int'(out_last), 0);
    check("rst_out_re", int'(out_re), 0);
    check("rst_out_im", int'(out_im), 0);
    @(negedge clk);
    rst = 1'b0;

    // T1 identity
    t1r  = '{1, 2, 0, 0, 1, 0, 0, 1};
    t1i  = '{1, 0, 0, -1, 0, 0, 0, 0};
    t1er = '{1, 2, 0, 0};
    t1ei = '{1, 0, 0, -1};
    load(t1r, t1i, 1'b0, 1'b0, 1'b0);
    collect(t1er, t1ei, -1, 1'b0);

    // T2 extremes
    for (int b = 0; b < 8; b++) begin ar[b] = -128; ai[b] = -128; end
    er = '{0, 0, 0, 0};
    ei = '{65536, 65536, 65536, 65536};
    load(ar, ai, 1'b0, 1'b0, 1'b0);
    collect(er, ei, -1, 1'b0);

    // T3 Hermitian, herm toggled after beat 0
    ar = '{1, 0, 0, 1, 1, 3, 0, 5};
    ai = '{0, 0, 0, 0, 2, 0, 4, 0};
    er = '{1, 0, 3, 5};
    ei = '{-2, -4, 0, 0};
    load(ar, ai, 1'b1, 1'b1, 1'b0);
    collect(er, ei, -1, 1'b0);

    // T4 backpressure on C01
    load(t1r, t1i, 1'b0, 1'b0, 1'b1);
    collect(t1er, t1ei, 1, 1'b0);

    // T5 reset during COMPUTE step k=3, then T1
    for (int b = 0; b < 8; b++) begin
      ar[b] = int'($urandom_range(0, 255)) - 128;
      ai[b] = int'($urandom_range(0, 255)) - 128;
    end
    load(ar, ai, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("t5_in_ready", int'(in_ready), 1);
    check("t5_out_valid", int'(out_valid), 0);
    check("t5_busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    load(t1r, t1i, 1'b0, 1'b0, 1'b0);
    collect(t1er, t1ei, -1, 1'b0);

    // T6 junk on the input while busy, then a random matrix
    load(t1r, t1i, 1'b0, 1'b0, 1'b0);
    collect(t1er, t1ei, -1, 1'b1);
    for (int b = 0; b < 8; b++) begin
      ar[b] = int'($urandom_range(0, 255)) - 128;
      ai[b] = int'($urandom_range(0, 255)) - 128;
    end
    ref_model(ar, ai, 1'b0, er, ei);
    load(ar, ai, 1'b0, 1'b0, 1'b0);
    collect(er, ei, -1, 1'b0);

    // Random matrices with random mode, gaps, stalls and junk
    for (int n = 0; n < 24; n++) begin
      bit h;
      int st;
      for (int b = 0; b < 8; b++) begin
        ar[b] = int'($urandom_range(0, 255)) - 128;
        ai[b] = int'($urandom_range(0, 255)) - 128;
      end
      h  = 1'($urandom);
      st = int'($urandom_range(0, 5)) - 2;
      ref_model(ar, ai, h, er, ei);
      load(ar, ai, h, 1'($urandom), 1'($urandom));
      collect(er, ei, st, 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
